// File: rtl/rv32_instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, word-by-word line refill
// over a request/valid handshake, and whole-cache invalidate for fence.i.
module rv32_instr_cache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_bus,
  output logic        instr_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int W_BITS    = $clog2(WORDS_PER_LINE);
  localparam int I_BITS    = $clog2(LINES);
  localparam int TAG_LSB   = W_BITS + I_BITS + 2;
  localparam int TAG_BITS  = 32 - TAG_LSB;
  localparam int LINE_BITS = TAG_BITS + I_BITS;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [LINES-1:0]      valid_r;
  logic [TAG_BITS-1:0]   tag_mem_r  [LINES];
  logic [31:0]           data_mem_r [LINES][WORDS_PER_LINE];
  logic [W_BITS-1:0]     word_cnt_r;
  logic [W_BITS-1:0]     word_inc_s;
  logic [LINE_BITS-1:0]  fill_line_r;
  logic                  flush_pend_r;
  logic                  mem_req_r;
  logic [31:0]           mem_addr_r;

  logic [I_BITS-1:0]     idx_s;
  logic [W_BITS-1:0]     word_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  lookup_hit_s;
  logic                  start_fill_s;
  logic                  last_word_s;
  logic [I_BITS-1:0]     fill_idx_s;
  logic [TAG_BITS-1:0]   fill_tag_s;
  logic                  unused_addr_s;

  assign idx_s         = instr_addr[TAG_LSB-1:W_BITS+2];
  assign word_s        = instr_addr[W_BITS+1:2];
  assign tag_s         = instr_addr[31:TAG_LSB];
  assign unused_addr_s = ^instr_addr[1:0];

  assign fill_idx_s  = fill_line_r[I_BITS-1:0];
  assign fill_tag_s  = fill_line_r[LINE_BITS-1:I_BITS];
  assign word_inc_s  = word_cnt_r + W_BITS'(1);
  assign last_word_s = (word_cnt_r == W_BITS'(WORDS_PER_LINE - 1));

  assign lookup_hit_s = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  assign start_fill_s = (state_r == ST_IDLE) && !flush && !lookup_hit_s;

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

  // Hit path: only an IDLE lookup without a flush may deliver an instruction
  always_comb begin
    instr_ready = 1'b0;
    instr_bus   = 32'h0000_0000;
    if ((state_r == ST_IDLE) && !flush && lookup_hit_s) begin
      instr_ready = 1'b1;
      instr_bus   = data_mem_r[idx_s][word_s];
    end else begin
      instr_ready = 1'b0;
      instr_bus   = 32'h0000_0000;
    end
  end

  // Refill FSM next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_fill_s) begin
          state_next_s = ST_REFILL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REFILL: begin
        if (mem_valid && last_word_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REFILL;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Control state: FSM, word counter, valid bits, pending flush and memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      word_cnt_r   <= '0;
      fill_line_r  <= '0;
      valid_r      <= '0;
      flush_pend_r <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          flush_pend_r <= 1'b0;
          if (flush) begin
            valid_r <= '0;
          end else if (start_fill_s) begin
            fill_line_r <= instr_addr[31:W_BITS+2];
            word_cnt_r  <= '0;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= {instr_addr[31:W_BITS+2], {(W_BITS + 2){1'b0}}};
          end else begin
            mem_req_r <= 1'b0;
          end
        end
        ST_REFILL: begin
          // A flush anywhere in the refill, including the final beat, keeps the line invalid
          if (mem_valid && last_word_s) begin
            word_cnt_r   <= '0;
            mem_req_r    <= 1'b0;
            flush_pend_r <= 1'b0;
            if (flush) begin
              valid_r <= '0;
            end else if (!flush_pend_r) begin
              valid_r[fill_idx_s] <= 1'b1;
            end
          end else begin
            if (mem_valid) begin
              word_cnt_r <= word_inc_s;
              mem_addr_r <= {fill_line_r, word_inc_s, 2'b00};
            end
            if (flush) begin
              valid_r      <= '0;
              flush_pend_r <= 1'b1;
            end
          end
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: data and tags carry no reset, the valid bits guard them
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_REFILL) && mem_valid) begin
      data_mem_r[fill_idx_s][word_cnt_r] <= mem_rdata;
      if (last_word_s) begin
        tag_mem_r[fill_idx_s] <= fill_tag_s;
      end
    end
  end

endmodule
